mandel_frame_dispatcher: RTL

- Frame-level master for the Mandelbrot iterator: walks a raster of H_RES x V_RES pixels and maps each pixel to a Q4.23 complex coordinate.
- Issues each coordinate on the iterator's input val/rdy interface and accepts the iterator's result on its output val/rdy interface.
- Forwards each result as a pixel write (linear address, iteration count, escape flag) on a third val/rdy interface toward the framebuffer.
- Sits between the frame-control logic and the iterator.

---
 rtl/mandel_frame_dispatcher.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/mandel_frame_dispatcher.sv
// Frame master for the Mandelbrot iterator: rasters H_RES x V_RES pixels, issues one
// Q4.23 coordinate at a time and forwards each result as a framebuffer pixel write.
module mandel_frame_dispatcher #(
  parameter int H_RES    = 640,
  parameter int V_RES    = 480,
  parameter int ITER_MAX = 1000,
  parameter int IW       = $clog2(ITER_MAX) + 1,
  parameter int AW       = $clog2(H_RES * V_RES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [26:0]   x_min,
  input  logic [26:0]   y_max,
  input  logic [26:0]   step,
  output logic          busy,
  output logic          done,
  output logic          it_in_val,
  input  logic          it_in_rdy,
  output logic [26:0]   it_c_r,
  output logic [26:0]   it_c_i,
  input  logic          it_out_val,
  output logic          it_out_rdy,
  input  logic [IW-1:0] it_iter_count,
  input  logic          it_escape,
  output logic          pix_val,
  input  logic          pix_rdy,
  output logic [AW-1:0] pix_addr,
  output logic [IW-1:0] pix_iter,
  output logic          pix_escape
);

  localparam int XW = $clog2(H_RES + 1);
  localparam int YW = $clog2(V_RES + 1);
  localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    WRITE,
    DONE
  } state_t;

  state_t        state_q;
  logic [26:0]   xMin_q;
  logic [26:0]   step_q;
  logic [26:0]   cr_q;
  logic [26:0]   ci_q;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic [AW-1:0] addr_q;
  logic [IW-1:0] pixIter_q;
  logic          pixEscape_q;
  logic          busy_q;
  logic          done_q;
  logic          inVal_q;
  logic          outRdy_q;
  logic          pixVal_q;

  // Coordinates advance incrementally; 27-bit adds wrap, matching the modular raster mapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      xMin_q      <= '0;
      step_q      <= '0;
      cr_q        <= '0;
      ci_q        <= '0;
      x_q         <= '0;
      y_q         <= '0;
      addr_q      <= '0;
      pixIter_q   <= '0;
      pixEscape_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      inVal_q     <= 1'b0;
      outRdy_q    <= 1'b0;
      pixVal_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            xMin_q  <= x_min;
            step_q  <= step;
            cr_q    <= x_min;
            ci_q    <= y_max;
            x_q     <= '0;
            y_q     <= '0;
            addr_q  <= '0;
            busy_q  <= 1'b1;
            inVal_q <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (inVal_q && it_in_rdy) begin
            inVal_q  <= 1'b0;
            outRdy_q <= 1'b1;
            state_q  <= WAIT;
          end
        end
        WAIT: begin
          if (it_out_val && outRdy_q) begin
            outRdy_q    <= 1'b0;
            pixIter_q   <= it_iter_count;
            pixEscape_q <= it_escape;
            pixVal_q    <= 1'b1;
            state_q     <= WRITE;
          end
        end
        WRITE: begin
          if (pixVal_q && pix_rdy) begin
            pixVal_q <= 1'b0;
            if (x_q == X_LAST && y_q == Y_LAST) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              addr_q  <= addr_q + 1'b1;
              inVal_q <= 1'b1;
              state_q <= ISSUE;
              if (x_q == X_LAST) begin
                x_q  <= '0;
                cr_q <= xMin_q;
                y_q  <= y_q + 1'b1;
                ci_q <= ci_q - step_q;
              end else begin
                x_q  <= x_q + 1'b1;
                cr_q <= cr_q + step_q;
              end
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign it_in_val  = inVal_q;
  assign it_c_r     = cr_q;
  assign it_c_i     = ci_q;
  assign it_out_rdy = outRdy_q;
  assign pix_val    = pixVal_q;
  assign pix_addr   = addr_q;
  assign pix_iter   = pixIter_q;
  assign pix_escape = pixEscape_q;

endmodule
